// File: rtl/a51_pkg.sv
`default_nettype none
// ============================================================================
// a51_pkg
// Shared constants, state encoding and helpers for the A5/1 LFSR core.
// Revision: 1.0
// ============================================================================
package a51_pkg;

  // Register lengths
  localparam int R1_LEN = 19;
  localparam int R2_LEN = 22;
  localparam int R3_LEN = 23;

  // Feedback tap masks (bit set = tap position)
  localparam logic [R1_LEN-1:0] R1_TAPS = 19'h7_2000;   // 18,17,16,13
  localparam logic [R2_LEN-1:0] R2_TAPS = 22'h30_0000;  // 21,20
  localparam logic [R3_LEN-1:0] R3_TAPS = 23'h70_0080;  // 22,21,20,7

  // Clock-control bit positions
  localparam int R1_CLK = 8;
  localparam int R2_CLK = 10;
  localparam int R3_CLK = 10;

  // Phase lengths of a session
  localparam int KEY_LEN   = 64;
  localparam int FRAME_LEN = 22;
  localparam int MIX_LEN   = 100;

  // Session FSM encoding
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_KEY   = 3'd1,
    ST_FRAME = 3'd2,
    ST_MIX   = 3'd3,
    ST_OUT   = 3'd4
  } a51_state_t;

  // Majority of three clock-control bits
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage : a51_pkg
`default_nettype wire

// File: rtl/a51_lfsr.sv
`default_nettype none
// ============================================================================
// a51_lfsr
// One A5/1 shift register: shifts toward the MSB, feedback XOR inject into
// bit 0. The msb output is the MSB the register will hold after the current
// edge, so the core can register keystream from post-shift contents.
// Revision: 1.0
// ============================================================================
module a51_lfsr #(
  parameter int              LEN     = 19,
  parameter logic [LEN-1:0]  TAPS    = '0,
  parameter int              CLK_BIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic shift,
  input  logic inject,
  input  logic clear,
  output logic msb,
  output logic clk_bit
);

  logic [LEN-1:0] r;
  logic           fb;

  assign fb      = ^(r & TAPS);
  assign clk_bit = r[CLK_BIT];

  // Look-ahead MSB: a clear empties the upper bits, a shift promotes bit LEN-2
  assign msb = clear ? 1'b0 : (shift ? r[LEN-2] : r[LEN-1]);

  // Register update: clear (optionally with first shift) or plain shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r <= '0;
    end else if (clear) begin
      r <= shift ? {{(LEN-1){1'b0}}, inject} : '0;
    end else if (shift) begin
      r <= {r[LEN-2:0], fb ^ inject};
    end
  end

endmodule : a51_lfsr
`default_nettype wire

// File: rtl/a51_lfsr_core.sv
`default_nettype none
// ============================================================================
// a51_lfsr_core
// A5/1 keystream core: key load, frame load, majority mixing and keystream
// generation, sequenced by a one-hot phase from an upstream stage counter.
// Revision: 1.0
// ============================================================================
module a51_lfsr_core
  import a51_pkg::*;
(
  input  logic        C,
  input  logic        CLR_N,
  input  logic        ENABLE,
  input  logic        STAGEONE,
  input  logic        STAGETWO,
  input  logic        STAGETHREE,
  input  logic        OUTPUTSTAGE,
  input  logic [63:0] KEY,
  input  logic [21:0] FRAME,
  input  logic        DATAIN,
  output logic        KSBIT,
  output logic        CIPHERBIT,
  output logic        KSVALID,
  output logic        STAGEERR
);

  a51_state_t state, state_next;
  logic [6:0] kidx, kidx_next;
  logic [4:0] fidx, fidx_next;

  logic [3:0] phase;
  logic       sh1, sh2, sh3, inj, clr, ks_fire, err_set;
  logic       msb1, msb2, msb3, cb1, cb2, cb3, maj;
  logic       ks_bit;

  assign phase  = {STAGEONE, STAGETWO, STAGETHREE, OUTPUTSTAGE};
  assign maj    = majority3(cb1, cb2, cb3);
  assign ks_bit = msb1 ^ msb2 ^ msb3;

  a51_lfsr #(.LEN(R1_LEN), .TAPS(R1_TAPS), .CLK_BIT(R1_CLK)) u_r1 (
    .clk(C), .rst_n(CLR_N), .shift(sh1), .inject(inj), .clear(clr),
    .msb(msb1), .clk_bit(cb1)
  );

  a51_lfsr #(.LEN(R2_LEN), .TAPS(R2_TAPS), .CLK_BIT(R2_CLK)) u_r2 (
    .clk(C), .rst_n(CLR_N), .shift(sh2), .inject(inj), .clear(clr),
    .msb(msb2), .clk_bit(cb2)
  );

  a51_lfsr #(.LEN(R3_LEN), .TAPS(R3_TAPS), .CLK_BIT(R3_CLK)) u_r3 (
    .clk(C), .rst_n(CLR_N), .shift(sh3), .inject(inj), .clear(clr),
    .msb(msb3), .clk_bit(cb3)
  );

  // Phase decode: next state, register control and index updates
  always_comb begin
    state_next = state;
    kidx_next  = kidx;
    fidx_next  = fidx;
    sh1        = 1'b0;
    sh2        = 1'b0;
    sh3        = 1'b0;
    inj        = 1'b0;
    clr        = 1'b0;
    ks_fire    = 1'b0;
    err_set    = 1'b0;
    if (ENABLE) begin
      if (!$onehot(phase)) begin
        // Illegal encoding: freeze everything, just flag it
        err_set = 1'b1;
      end else begin
        case (phase)
          4'b1000: begin
            state_next = ST_KEY;
            if (state != ST_KEY) begin
              // New session: clear and take key bit 0 on the same edge
              clr       = 1'b1;
              {sh1, sh2, sh3} = 3'b111;
              inj       = KEY[0];
              kidx_next = 7'd1;
              fidx_next = 5'd0;
            end else if (kidx < 7'(KEY_LEN)) begin
              {sh1, sh2, sh3} = 3'b111;
              inj       = KEY[kidx[5:0]];
              kidx_next = kidx + 7'd1;
            end
          end
          4'b0100: begin
            state_next = ST_FRAME;
            if (fidx < 5'(FRAME_LEN)) begin
              {sh1, sh2, sh3} = 3'b111;
              inj       = FRAME[fidx];
              fidx_next = fidx + 5'd1;
            end
          end
          4'b0010: begin
            state_next = ST_MIX;
            sh1 = (cb1 == maj);
            sh2 = (cb2 == maj);
            sh3 = (cb3 == maj);
          end
          default: begin
            state_next = ST_OUT;
            sh1     = (cb1 == maj);
            sh2     = (cb2 == maj);
            sh3     = (cb3 == maj);
            ks_fire = 1'b1;
          end
        endcase
      end
    end
  end

  // State and index registers
  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      state <= ST_IDLE;
      kidx  <= '0;
      fidx  <= '0;
    end else begin
      state <= state_next;
      kidx  <= kidx_next;
      fidx  <= fidx_next;
    end
  end

  // Output registers: keystream captured from post-shift contents
  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      KSBIT     <= 1'b0;
      CIPHERBIT <= 1'b0;
      KSVALID   <= 1'b0;
      STAGEERR  <= 1'b0;
    end else begin
      KSVALID  <= ks_fire;
      STAGEERR <= STAGEERR | err_set;
      if (ks_fire) begin
        KSBIT     <= ks_bit;
        CIPHERBIT <= ks_bit ^ DATAIN;
      end
    end
  end

endmodule : a51_lfsr_core
`default_nettype wire
